// File: rtl/triplet_stream_tx_pkg.sv
// Shared types for the triplet operand stream: lane index and triplet layout.
// Imported by the transmitter and reusable by the receive-side logic.
package triplet_stream_tx_pkg;

    localparam int unsigned DEFAULT_IO_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        LANE0,
        LANE1,
        LANE2
    } lane_e;

    // Layout of one buffered triplet at the default lane width; lane0 is the first word received.
    typedef struct packed {
        logic                             last;
        logic [DEFAULT_IO_DATA_WIDTH-1:0] lane2;
        logic [DEFAULT_IO_DATA_WIDTH-1:0] lane1;
        logic [DEFAULT_IO_DATA_WIDTH-1:0] lane0;
    } triplet_t;

    function automatic lane_e next_lane(input lane_e cur);
        case (cur)
            LANE0:   return LANE1;
            LANE1:   return LANE2;
            default: return LANE0;
        endcase
    endfunction

endpackage

// File: rtl/triplet_fifo.sv
// Small register-based FIFO with registered head, exact level and synchronous clear.
// Used for triplets on both the transmit and receive side of the operand stream.
module triplet_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_comb begin
        head_data = mem_q[rd_ptr_q];
        full      = (level_q == LVL_W'(DEPTH));
        empty     = (level_q == '0);
        level     = level_q;
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/triplet_stream_tx.sv
// Packs host words into triplets, buffers them and presents them on a
// three-lane valid/ready stream with frame-boundary marking.
module triplet_stream_tx
    import triplet_stream_tx_pkg::*;
#(
    parameter int unsigned IO_DATA_WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH         = 4,
    parameter int unsigned TRIPLETS_PER_FRAME = 64
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic [IO_DATA_WIDTH-1:0]      host_word,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic                          flush,
    output logic [IO_DATA_WIDTH-1:0]      tx_data0,
    output logic [IO_DATA_WIDTH-1:0]      tx_data1,
    output logic [IO_DATA_WIDTH-1:0]      tx_data2,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          tx_last,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned TRIP_W = 3 * IO_DATA_WIDTH;
    localparam int unsigned CNT_W  = (TRIPLETS_PER_FRAME > 1) ? $clog2(TRIPLETS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TRIPLETS_PER_FRAME - 1);

    lane_e                    lane_q, lane_d;
    logic [IO_DATA_WIDTH-1:0] pack0_q, pack0_d;
    logic [IO_DATA_WIDTH-1:0] pack1_q, pack1_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     frame_done_q, frame_done_d;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     accept;
    logic                     push;
    logic                     pop;
    logic [TRIP_W-1:0]        push_data;
    logic [TRIP_W-1:0]        head_data;

    // host_ready depends only on registered state, never on tx_ready.
    always_comb begin
        host_ready = !((lane_q == LANE2) && fifo_full);
        accept     = host_valid && host_ready;
        push       = accept && (lane_q == LANE2);
        push_data  = {host_word, pack1_q, pack0_q};
        tx_valid   = !fifo_empty;
        pop        = tx_valid && tx_ready;
        tx_data0   = head_data[IO_DATA_WIDTH-1:0];
        tx_data1   = head_data[2*IO_DATA_WIDTH-1:IO_DATA_WIDTH];
        tx_data2   = head_data[3*IO_DATA_WIDTH-1:2*IO_DATA_WIDTH];
        tx_last    = tx_valid && (count_q == LAST_CNT);
        frame_done = frame_done_q;
    end

    always_comb begin
        lane_d       = lane_q;
        pack0_d      = pack0_q;
        pack1_d      = pack1_q;
        count_d      = count_q;
        frame_done_d = 1'b0;
        if (flush) begin
            lane_d  = LANE0;
            count_d = '0;
        end else begin
            if (accept) begin
                if (lane_q == LANE0) pack0_d = host_word;
                if (lane_q == LANE1) pack1_d = host_word;
                lane_d = next_lane(lane_q);
            end
            if (pop) begin
                if (count_q == LAST_CNT) begin
                    count_d      = '0;
                    frame_done_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            lane_q       <= LANE0;
            pack0_q      <= '0;
            pack1_q      <= '0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            pack0_q      <= pack0_d;
            pack1_q      <= pack1_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
        end
    end

    triplet_fifo #(
        .WIDTH (TRIP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (arst_n_in),
        .clear     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_triplet_stream_tx.sv
// Directed bench for triplet_stream_tx: vector table for the basic/frame flow,
// hand-written sequences for backpressure, push/pop overlap, flush and async reset.
module tb_triplet_stream_tx;
    import triplet_stream_tx_pkg::*;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         arst_n_in = 1'b0;
    logic [W-1:0] host_word = '0;
    logic         host_valid = 1'b0;
    logic         host_ready;
    logic         flush = 1'b0;
    logic [W-1:0] tx_data0, tx_data1, tx_data2;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         tx_last;
    logic         frame_done;
    logic [2:0]   fifo_level;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    triplet_stream_tx #(
        .IO_DATA_WIDTH      (W),
        .FIFO_DEPTH         (4),
        .TRIPLETS_PER_FRAME (2)
    ) dut (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .host_word  (host_word),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .flush      (flush),
        .tx_data0   (tx_data0),
        .tx_data1   (tx_data1),
        .tx_data2   (tx_data2),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .frame_done (frame_done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         hv;
        logic [W-1:0] w;
        logic         trdy;
        logic         e_hr;
        logic         e_tv;
        logic [W-1:0] e0, e1, e2;
        logic         e_last;
        logic         e_fd;
        logic [2:0]   e_lvl;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; holds the word until it is accepted, then returns at the following negedge.
    task automatic send(input logic [W-1:0] w);
        int unsigned n;
        n = 0;
        host_valid = 1'b1;
        host_word  = w;
        while (!host_ready && n < 20) begin
            tick();
            n++;
        end
        if (!host_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word 0x%0h not accepted within 20 cycles", w);
        end
        tick();
        host_valid = 1'b0;
    endtask

    task automatic chk_head(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c);
        chk({name, "_d0"}, 32'(tx_data0), 32'(a));
        chk({name, "_d1"}, 32'(tx_data1), 32'(b));
        chk({name, "_d2"}, 32'(tx_data2), 32'(c));
    endtask

    initial begin
        triplet_t    exp_t [5];
        int unsigned lv [5];
        logic        prev_last;
        logic [W-1:0] s0, s1, s2;

        //            hv  w   trdy  hr  tv   e0 e1 e2  last fd lvl
        vecs[0] = '{1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 16'd2, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 3'd0};
        vecs[2] = '{1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 3'd0};
        vecs[3] = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b1, 16'd1, 16'd2, 16'd3, 1'b0, 1'b0, 3'd1};
        vecs[4] = '{1'b1, 16'd5, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 3'd0};
        vecs[5] = '{1'b1, 16'd6, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 3'd0};
        vecs[6] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 16'd4, 16'd5, 16'd6, 1'b1, 1'b0, 3'd1};
        vecs[7] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 3'd0};
        vecs[8] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 3'd0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        arst_n_in = 1'b1;
        chk("rst_host_ready", 32'(host_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk_head("rst", 16'd0, 16'd0, 16'd0);

        // Basic packing and a two-triplet frame
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("vec%0d_host_ready", i), 32'(host_ready), 32'(vecs[i].e_hr));
            chk($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(vecs[i].e_tv));
            chk($sformatf("vec%0d_tx_last", i), 32'(tx_last), 32'(vecs[i].e_last));
            chk($sformatf("vec%0d_frame_done", i), 32'(frame_done), 32'(vecs[i].e_fd));
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].e_lvl));
            if (vecs[i].e_tv) begin
                chk_head($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2);
            end
            host_valid = vecs[i].hv;
            host_word  = vecs[i].w;
            tx_ready   = vecs[i].trdy;
            tick();
        end
        host_valid = 1'b0;
        tx_ready   = 1'b0;

        // Backpressure: 14 words fill four triplets plus a partial one
        for (int i = 0; i < 14; i++) begin
            send(16'(101 + i));
        end
        chk("bp_host_ready_low", 32'(host_ready), 32'd0);
        chk("bp_level_full", 32'(fifo_level), 32'd4);
        chk("bp_tx_valid", 32'(tx_valid), 32'd1);
        chk_head("bp_head", 16'd101, 16'd102, 16'd103);
        host_valid = 1'b1;
        host_word  = 16'd115;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_valid", 32'(tx_valid), 32'd1);
            chk("bp_stall_host_ready", 32'(host_ready), 32'd0);
            chk_head("bp_stall", 16'd101, 16'd102, 16'd103);
        end

        for (int k = 0; k < 5; k++) begin
            exp_t[k].lane0 = 16'(101 + 3 * k);
            exp_t[k].lane1 = 16'(102 + 3 * k);
            exp_t[k].lane2 = 16'(103 + 3 * k);
            exp_t[k].last  = (k % 2 == 1);
        end
        lv = '{4, 3, 3, 2, 1};
        prev_last = 1'b0;
        tx_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("drain%0d_tx_valid", k), 32'(tx_valid), 32'd1);
            chk_head($sformatf("drain%0d", k), exp_t[k].lane0, exp_t[k].lane1, exp_t[k].lane2);
            chk($sformatf("drain%0d_tx_last", k), 32'(tx_last), 32'(exp_t[k].last));
            chk($sformatf("drain%0d_frame_done", k), 32'(frame_done), 32'(prev_last));
            chk($sformatf("drain%0d_level", k), 32'(fifo_level), lv[k]);
            if (k == 0) chk("drain0_host_ready", 32'(host_ready), 32'd0);
            if (k == 1) chk("drain1_host_ready", 32'(host_ready), 32'd1);
            prev_last = exp_t[k].last;
            tick();
            if (k == 1) host_valid = 1'b0;
        end
        chk("drain_end_tx_valid", 32'(tx_valid), 32'd0);
        chk("drain_end_level", 32'(fifo_level), 32'd0);
        chk("drain_end_frame_done", 32'(frame_done), 32'(prev_last));
        tx_ready = 1'b0;

        // Flush with two triplets buffered and a partial triplet in the packer
        for (int i = 0; i < 6; i++) begin
            send(16'(30 + i));
        end
        send(16'd10);
        send(16'd11);
        chk("pre_flush_level", 32'(fifo_level), 32'd2);
        chk("pre_flush_tx_valid", 32'(tx_valid), 32'd1);
        s0 = tx_data0;
        s1 = tx_data1;
        s2 = tx_data2;
        chk_head("pre_flush_head", 16'd30, 16'd31, 16'd32);
        flush      = 1'b1;
        host_valid = 1'b1;
        host_word  = 16'd99;
        tx_ready   = 1'b1;
        tick();
        flush      = 1'b0;
        host_valid = 1'b0;
        tx_ready   = 1'b0;
        chk("flush_tx_valid", 32'(tx_valid), 32'd0);
        chk("flush_level", 32'(fifo_level), 32'd0);
        chk("flush_host_ready", 32'(host_ready), 32'd1);
        chk("flush_frame_done", 32'(frame_done), 32'd0);
        send(16'd20);
        send(16'd21);
        send(16'd22);
        chk("post_flush_tx_valid", 32'(tx_valid), 32'd1);
        chk_head("post_flush_head", 16'd20, 16'd21, 16'd22);
        chk("post_flush_tx_last", 32'(tx_last), 32'd0);
        chk("post_flush_level", 32'(fifo_level), 32'd1);

        // Asynchronous reset with a triplet pending and a partial word in the packer
        send(16'd40);
        #2;
        arst_n_in = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(tx_valid), 32'd0);
        chk("arst_host_ready", 32'(host_ready), 32'd1);
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_tx_data0", 32'(tx_data0), 32'd0);
        chk("arst_tx_last", 32'(tx_last), 32'd0);
        @(negedge clk);
        arst_n_in = 1'b1;
        send(16'd50);
        send(16'd51);
        send(16'd52);
        chk("post_arst_tx_valid", 32'(tx_valid), 32'd1);
        chk_head("post_arst_head", 16'd50, 16'd51, 16'd52);
        chk("post_arst_stale_head", 32'(tx_data0 == s0 && tx_data1 == s1 && tx_data2 == s2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
